// File: rtl/xadc_drp_pkg.sv
// Shared constants, FSM state type and result formatting for the XADC DRP responder.
package xadc_drp_pkg;

    localparam logic [6:0] ADDR_VAUX6 = 7'h16;
    localparam logic [6:0] ADDR_VAUX7 = 7'h17;
    localparam logic [6:0] ADDR_CFG0  = 7'h40;
    localparam logic [6:0] ADDR_CFG1  = 7'h41;
    localparam logic [6:0] ADDR_CFG2  = 7'h42;

    localparam int RESULT_LSB_PAD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } drp_state_e;

    // Result registers hold the 12-bit code left-justified in a 16-bit word.
    function automatic logic [15:0] pad_result(input logic [11:0] code);
        return {code, {RESULT_LSB_PAD{1'b0}}};
    endfunction

endpackage

// File: rtl/xadc_sample_store.sv
// Per-channel auxiliary result registers fed from the sample stream, with eoc/channel reporting.
// Optional 4-sample averaging is enabled by defining XADC_RESP_AVG_EN.
module xadc_sample_store
    import xadc_drp_pkg::*;
(
    input  logic        clk_100MHz,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic        sample_ch,
    input  logic [11:0] sample_data,
    output logic [15:0] vaux6_out,
    output logic [15:0] vaux7_out,
    output logic        eoc_out,
    output logic [6:0]  channel_out
);

    logic [1:0][11:0] res_q, res_d;
    logic             eoc_q, eoc_d;
    logic [6:0]       chan_q, chan_d;

`ifdef XADC_RESP_AVG_EN
    logic [1:0][1:0]  cnt_q, cnt_d;
    logic [1:0][13:0] acc_q, acc_d;
    logic [13:0]      sum;
`endif

    always_comb begin
        res_d  = res_q;
        eoc_d  = 1'b0;
        chan_d = chan_q;
`ifdef XADC_RESP_AVG_EN
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        sum    = acc_q[sample_ch] + 14'(sample_data);
`endif
        if (sample_valid) begin
`ifdef XADC_RESP_AVG_EN
            // Four 12-bit codes fit in 14 bits, so the sum never wraps.
            if (cnt_q[sample_ch] == 2'd3) begin
                res_d[sample_ch] = sum[13:2];
                acc_d[sample_ch] = '0;
                cnt_d[sample_ch] = '0;
                eoc_d            = 1'b1;
                chan_d           = sample_ch ? ADDR_VAUX7 : ADDR_VAUX6;
            end else begin
                acc_d[sample_ch] = sum;
                cnt_d[sample_ch] = cnt_q[sample_ch] + 2'd1;
            end
`else
            res_d[sample_ch] = sample_data;
            eoc_d            = 1'b1;
            chan_d           = sample_ch ? ADDR_VAUX7 : ADDR_VAUX6;
`endif
        end
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            res_q  <= '0;
            eoc_q  <= 1'b0;
            chan_q <= '0;
`ifdef XADC_RESP_AVG_EN
            cnt_q  <= '0;
            acc_q  <= '0;
`endif
        end else begin
            res_q  <= res_d;
            eoc_q  <= eoc_d;
            chan_q <= chan_d;
`ifdef XADC_RESP_AVG_EN
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
`endif
        end
    end

    assign vaux6_out   = pad_result(res_q[0]);
    assign vaux7_out   = pad_result(res_q[1]);
    assign eoc_out     = eoc_q;
    assign channel_out = chan_q;

endmodule

// File: rtl/xadc_drp_responder.sv
// Soft XADC DRP slave: fixed-latency read/write responder with config registers and aux results.
// Define XADC_RESP_AVG_EN to average every four samples per channel in the result store.
module xadc_drp_responder
    import xadc_drp_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 4
) (
    input  logic              clk_100MHz,
    input  logic              rst,
    input  logic [ADDR_W-1:0] daddr_in,
    input  logic              den_in,
    input  logic              dwe_in,
    input  logic [DATA_W-1:0] di_in,
    output logic [DATA_W-1:0] do_out,
    output logic              drdy_out,
    output logic              busy_out,
    input  logic              sample_valid,
    input  logic              sample_ch,
    input  logic [11:0]       sample_data,
    output logic              eoc_out,
    output logic [6:0]        channel_out,
    output logic              err_out
);

    drp_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic [DATA_W-1:0] cfg0_q, cfg0_d, cfg1_q, cfg1_d, cfg2_q, cfg2_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] read_mux;
    logic [15:0]       vaux6, vaux7;

    xadc_sample_store u_store (
        .clk_100MHz  (clk_100MHz),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sample_ch   (sample_ch),
        .sample_data (sample_data),
        .vaux6_out   (vaux6),
        .vaux7_out   (vaux7),
        .eoc_out     (eoc_out),
        .channel_out (channel_out)
    );

    always_comb begin
        case (daddr_in)
            ADDR_W'(ADDR_VAUX6): read_mux = DATA_W'(vaux6);
            ADDR_W'(ADDR_VAUX7): read_mux = DATA_W'(vaux7);
            ADDR_W'(ADDR_CFG0):  read_mux = cfg0_q;
            ADDR_W'(ADDR_CFG1):  read_mux = cfg1_q;
            ADDR_W'(ADDR_CFG2):  read_mux = cfg2_q;
            default:             read_mux = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        snap_d  = snap_q;
        cfg0_d  = cfg0_q;
        cfg1_d  = cfg1_q;
        cfg2_d  = cfg2_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (den_in) begin
                    we_d    = dwe_in;
                    addr_d  = daddr_in;
                    wdata_d = di_in;
                    snap_d  = read_mux;
                    cnt_d   = 4'(RD_LATENCY - 1);
                    state_d = (RD_LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP: begin
                // Writes to read-only or unmapped addresses are silently dropped.
                if (we_q) begin
                    if (addr_q == ADDR_W'(ADDR_CFG0)) cfg0_d = wdata_q;
                    if (addr_q == ADDR_W'(ADDR_CFG1)) cfg1_d = wdata_q;
                    if (addr_q == ADDR_W'(ADDR_CFG2)) cfg2_d = wdata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (den_in && (state_q != IDLE)) err_d = 1'b1;
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            snap_q  <= '0;
            cfg0_q  <= '0;
            cfg1_q  <= '0;
            cfg2_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            snap_q  <= snap_d;
            cfg0_q  <= cfg0_d;
            cfg1_q  <= cfg1_d;
            cfg2_q  <= cfg2_d;
            err_q   <= err_d;
        end
    end

    assign drdy_out = (state_q == RESP);
    assign do_out   = (drdy_out && !we_q) ? snap_q : '0;
    assign busy_out = (state_q != IDLE);
    assign err_out  = err_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Self-checking bench for xadc_drp_responder: directed steps plus random traffic against a cycle-count model.
// Tracks XADC_RESP_AVG_EN so the model matches whichever build is compiled.
module tb_xadc_drp_responder;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  daddr = '0;
    logic        den = 1'b0;
    logic        dwe = 1'b0;
    logic [15:0] di = '0;
    logic [15:0] dout;
    logic        drdy, busy;
    logic        sv = 1'b0;
    logic        sch = 1'b0;
    logic [11:0] sdata = '0;
    logic        eoc;
    logic [6:0]  chan;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference model state: results as plain codes, config words, and one pending transaction by cycle number.
    int          cyc = 0;
    logic [11:0] mRes [2];
    logic [15:0] mCfg [3];
    bit          mErr, mPend, mWe, mEoc;
    int          mAcc;
    logic [6:0]  mAddr, mChan;
    logic [15:0] mWdata, mSnap;
    int          mCnt [2];
    int          mSum [2];

    logic [15:0] lastDo;
    int          drdyCnt = 0;
    int          eocCnt = 0;

    always #5 clk = ~clk;

    xadc_drp_responder #(.ADDR_W(7), .DATA_W(16), .RD_LATENCY(L)) dut (
        .clk_100MHz  (clk),
        .rst         (rst),
        .daddr_in    (daddr),
        .den_in      (den),
        .dwe_in      (dwe),
        .di_in       (di),
        .do_out      (dout),
        .drdy_out    (drdy),
        .busy_out    (busy),
        .sample_valid(sv),
        .sample_ch   (sch),
        .sample_data (sdata),
        .eoc_out     (eoc),
        .channel_out (chan),
        .err_out     (err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] readMap(input logic [6:0] a);
        case (a)
            7'h16:   return {mRes[0], 4'b0000};
            7'h17:   return {mRes[1], 4'b0000};
            7'h40:   return mCfg[0];
            7'h41:   return mCfg[1];
            7'h42:   return mCfg[2];
            default: return 16'h0000;
        endcase
    endfunction

    task automatic modelReset();
        mRes[0] = '0; mRes[1] = '0;
        mCfg[0] = '0; mCfg[1] = '0; mCfg[2] = '0;
        mErr = 0; mPend = 0; mWe = 0; mEoc = 0; mAcc = 0;
        mAddr = '0; mChan = '0; mWdata = '0; mSnap = '0;
        mCnt[0] = 0; mCnt[1] = 0; mSum[0] = 0; mSum[1] = 0;
    endtask

    task automatic checkOutput();
        bit expDrdy;
        expDrdy = mPend && (cyc == mAcc + L);
        chk("drdy", 16'(drdy), 16'(expDrdy));
        chk("busy", 16'(busy), 16'(mPend));
        chk("do_out", dout, (expDrdy && !mWe) ? mSnap : 16'h0000);
        chk("eoc", 16'(eoc), 16'(mEoc));
        chk("channel", 16'(chan), 16'(mChan));
        chk("err", 16'(err), 16'(mErr));
        if (drdy) begin
            lastDo = dout;
            drdyCnt++;
        end
        if (eoc) eocCnt++;
    endtask

    // Drive one cycle of inputs, advance the model across the edge ending this cycle, then check.
    task automatic applyStimulus(input bit iDen, input bit iWe, input logic [6:0] iAddr,
                                 input logic [15:0] iDi, input bit iSv, input bit iSch,
                                 input logic [11:0] iSd);
        bit wasPend;
        int s;
        den = iDen; dwe = iWe; daddr = iAddr; di = iDi;
        sv = iSv; sch = iSch; sdata = iSd;
        @(posedge clk);
        wasPend = mPend;
        if (iDen) begin
            if (wasPend) mErr = 1;
            else begin
                mPend = 1; mAcc = cyc; mWe = iWe; mAddr = iAddr; mWdata = iDi;
                mSnap = readMap(iAddr);
            end
        end
        if (wasPend && cyc == mAcc + L) begin
            if (mWe && mAddr >= 7'h40 && mAddr <= 7'h42) mCfg[mAddr - 7'h40] = mWdata;
            mPend = 0;
        end
        mEoc = 0;
        if (iSv) begin
`ifdef XADC_RESP_AVG_EN
            s = mSum[iSch] + int'(iSd);
            if (mCnt[iSch] == 3) begin
                mRes[iSch] = 12'(s / 4);
                mSum[iSch] = 0; mCnt[iSch] = 0;
                mEoc = 1; mChan = iSch ? 7'h17 : 7'h16;
            end else begin
                mSum[iSch] = s; mCnt[iSch]++;
            end
`else
            s = 0;
            mRes[iSch] = iSd;
            mEoc = 1; mChan = iSch ? 7'h17 : 7'h16;
`endif
        end
        cyc++;
        #1;
        den = 0; dwe = 0; sv = 0;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 7'h00, 16'h0, 0, 0, 12'h0);
    endtask

    task automatic readReg(input logic [6:0] a);
        applyStimulus(1, 0, a, 16'h0, 0, 0, 12'h0);
        idle(L + 1);
    endtask

    task automatic writeReg(input logic [6:0] a, input logic [15:0] d);
        applyStimulus(1, 1, a, d, 0, 0, 12'h0);
        idle(L + 1);
    endtask

    task automatic doReset();
        den = 0; dwe = 0; sv = 0;
        rst = 1;
        #1;
        chk("rst_do", dout, 16'h0);
        chk("rst_drdy", 16'(drdy), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_eoc", 16'(eoc), 16'h0);
        chk("rst_chan", 16'(chan), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        modelReset();
        @(posedge clk);
        #1;
        chk("rst_hold_drdy", 16'(drdy), 16'h0);
        chk("rst_hold_busy", 16'(busy), 16'h0);
        rst = 0;
    endtask

    initial begin
        logic [15:0] expX, expY;
        modelReset();
        doReset();

`ifdef XADC_RESP_AVG_EN
        expX = 16'h0000;
        expY = 16'h0000;
`else
        expX = 16'h8000;
        expY = 16'hABC0;
`endif

        // Sample then read VAUX6.
        applyStimulus(0, 0, 7'h00, 16'h0, 1, 0, 12'h800);
        applyStimulus(0, 0, 7'h00, 16'h0, 0, 0, 12'h0);
        readReg(7'h16);
        chk("rd_vaux6", lastDo, expX);

        // Config write/readback and dropped write to a result register.
        writeReg(7'h41, 16'h1234);
        readReg(7'h41);
        chk("rd_cfg1", lastDo, 16'h1234);
        writeReg(7'h17, 16'hFFFF);
        readReg(7'h17);
        chk("rd_vaux7_ro", lastDo, 16'h0000);

        // Overlapping request is rejected and flagged.
        drdyCnt = 0;
        applyStimulus(1, 0, 7'h41, 16'h0, 0, 0, 12'h0);
        idle(1);
        applyStimulus(1, 0, 7'h16, 16'h0, 0, 0, 12'h0);
        idle(L + 2);
        chk("collide_err", 16'(err), 16'h1);
        chk("collide_drdy_cnt", 16'(drdyCnt), 16'd1);
        chk("collide_data", lastDo, 16'h1234);

        // Sample landing with the read is not seen by that read.
        applyStimulus(1, 0, 7'h17, 16'h0, 1, 1, 12'hABC);
        idle(L + 1);
        chk("rd_vaux7_old", lastDo, 16'h0000);
        readReg(7'h17);
        chk("rd_vaux7_new", lastDo, expY);

        // Reset during WAIT of a write discards it.
        applyStimulus(1, 1, 7'h40, 16'h5555, 0, 0, 12'h0);
        idle(1);
        drdyCnt = 0;
        doReset();
        idle(L + 2);
        chk("rst_no_drdy", 16'(drdyCnt), 16'd0);
        readReg(7'h40);
        chk("rd_cfg0_after_rst", lastDo, 16'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [6:0] a;
            case ($urandom_range(0, 6))
                0: a = 7'h16;
                1: a = 7'h17;
                2: a = 7'h40;
                3: a = 7'h41;
                4: a = 7'h42;
                default: a = 7'($urandom);
            endcase
            applyStimulus(($urandom_range(0, 3) == 0), 1'($urandom), a, 16'($urandom),
                          1'($urandom), 1'($urandom), 12'($urandom));
        end

`ifdef XADC_RESP_AVG_EN
        // Averaging: four X samples produce one eoc and the truncated mean.
        doReset();
        eocCnt = 0;
        applyStimulus(0, 0, 7'h00, 16'h0, 1, 0, 12'd100);
        applyStimulus(0, 0, 7'h00, 16'h0, 1, 0, 12'd101);
        applyStimulus(0, 0, 7'h00, 16'h0, 1, 0, 12'd102);
        applyStimulus(0, 0, 7'h00, 16'h0, 1, 0, 12'd104);
        idle(2);
        chk("avg_eoc_cnt", 16'(eocCnt), 16'd1);
        readReg(7'h16);
        chk("avg_result", lastDo, {12'd101, 4'b0000});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xadc_drp_responder.md
# xadc_drp_responder

DRP responder that models the XADC dynamic reconfiguration port seen by the joystick read sequencer. It accepts single-cycle `den_in` requests, returns read data or write acknowledgement with a one-cycle `drdy_out` pulse after a fixed latency, and holds the auxiliary-channel result registers, which are fed from a sample stream. It is the slave end of the DRP interface, used as a soft stand-in for the hard XADC in simulation and in ADC-less builds.

## Interface
- `ADDR_W`, 7, DRP address width
- `DATA_W`, 16, DRP data width
- `RD_LATENCY`, 4, cycles from accepted `den_in` to `drdy_out`; legal range 1..15
- `clk_100MHz`  in  1  sole clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `daddr_in`  in  ADDR_W  request address, sampled when `den_in`=1
- `den_in`  in  1  request strobe, one cycle per request
- `dwe_in`  in  1  1 = write, 0 = read; sampled with `den_in`
- `di_in`  in  DATA_W  write data; sampled with `den_in`
- `do_out`  out  DATA_W  read data; valid only when `drdy_out`=1, otherwise 0
- `drdy_out`  out  1  one-cycle completion pulse
- `busy_out`  out  1  high from the cycle after acceptance through the `drdy_out` cycle
- `sample_valid`  in  1  new conversion result present
- `sample_ch`  in  1  0 = VAUX6 (X axis), 1 = VAUX7 (Y axis)
- `sample_data`  in  12  unsigned conversion code
- `eoc_out`  out  1  one-cycle end-of-conversion pulse
- `channel_out`  out  7  address of the last updated result register
- `err_out`  out  1  sticky protocol-error flag; cleared only by `rst`

## Operation
- Register map:
  - 0x16 = VAUX6 result, read-only.
  - 0x17 = VAUX7 result, read-only.
  - 0x40, 0x41, 0x42 = config registers, read/write.
  - All other addresses read 0x0000 and ignore writes.
- Result register format is `{code[11:0], 4'b0000}`.
- FSM `IDLE` -> `WAIT` -> `RESP` -> `IDLE`:
  - `IDLE`: on `den_in`=1, capture address, direction and write data, snapshot read data, load the latency counter with RD_LATENCY-1, then go to `WAIT`. If RD_LATENCY=1, go directly to `RESP`.
  - `WAIT`: decrement the counter; when it reaches 0, go to `RESP`.
  - `RESP`: assert `drdy_out`. For a read, drive the snapshot on `do_out`. For a write, commit `di_in` to the config register, or drop it if the target is read-only or unmapped. Return to `IDLE`.
- `den_in` while not in `IDLE` (including the `RESP` cycle): the request is ignored and `err_out` is set. The transaction in flight is unaffected.
- Read data is snapshotted at acceptance. A sample update in the same cycle as `den_in` is not visible in that read.
- Sample path:
  - On `sample_valid`, the selected result register is updated on the next edge.
  - `eoc_out` pulses in that same cycle, and `channel_out` = 0x16 or 0x17.
  - Back-to-back samples give back-to-back `eoc_out` pulses.
  - Sample updates are independent of DRP activity.
- Reset (any time, including mid-transaction):
  - The FSM returns to `IDLE`; any pending transaction is discarded with no `drdy_out` and no write commit.
  - All registers, `do_out`, `drdy_out`, `busy_out`, `eoc_out`, `channel_out` and `err_out` go to 0.

## Timing
- `den_in` accepted at edge N -> `drdy_out` high during cycle N+RD_LATENCY, for exactly one cycle.
- `busy_out` is high during cycles N+1 through N+RD_LATENCY.
- The earliest next accepted `den_in` is at edge N+RD_LATENCY+1.
- A write is visible to a read accepted at or after the `drdy_out` edge of that write.
- `sample_valid` at edge M -> register updated and `eoc_out` high during cycle M+1.

## Configuration
- `XADC_RESP_AVG_EN` defined:
  - Each channel has a 2-bit sample count and a 14-bit accumulator.
  - On every 4th accepted sample of a channel, the result register is loaded with `(sum+sample)>>2` (truncating), the accumulator is cleared, and `eoc_out` pulses.
  - Samples 1 to 3 update only the accumulator and produce no `eoc_out`.
- Not defined: every sample is stored directly and every sample pulses `eoc_out`.

## Structure
- Package `xadc_drp_pkg`:
  - Address constants `ADDR_VAUX6=7'h16`, `ADDR_VAUX7=7'h17`, `ADDR_CFG0..2`.
  - FSM state enum.
  - `RESULT_LSB_PAD=4`.
- Sub-module `xadc_sample_store`: the per-channel result registers, averaging logic and `eoc_out`/`channel_out` generation. The DRP FSM stays in the top module.

## Test plan
- Sample X=0x800, then read 0x16 with RD_LATENCY=4 -> `drdy_out` 4 cycles after `den_in`, `do_out`=0x8000, `eoc_out` one pulse with `channel_out`=0x16.
- Write 0x1234 to 0x41, then read 0x41 -> 0x1234. Write 0xFFFF to 0x17, then read 0x17 -> value unchanged.
- Second `den_in` 2 cycles after the first -> `err_out`=1, only one `drdy_out`, data from the first request.
- `sample_valid` (Y=0xABC) in the same cycle as a read of 0x17 -> returns the old value; a following read returns 0xABC0.
- Assert `rst` during `WAIT` of a write to 0x40 -> no `drdy_out`; a later read of 0x40 returns 0x0000; all outputs 0 while in reset.
- With `XADC_RESP_AVG_EN`, X samples 100, 101, 102, 104 -> a single `eoc_out` after the 4th sample; 0x16 reads `{12'd101, 4'b0}`.
